sha256_round_ctrl: RTL and testbench

Sequencer for the SHA-256 compression datapath. It accepts one 512-bit message block per start handshake and initialises the eight 32-bit hash registers to their IV on the first block. It then loads the working variables, steps the 64 rounds while supplying the round index and schedule select, and commits the final add into the hash registers. It sits between the host-side block interface and the hash register bank / round datapath.

---
 rtl/sha256_pkg.sv | 25 ++
 rtl/sha256_round_ctrl_if.sv | 51 +++++
 rtl/sha256_round_counter.sv | 33 +++
 rtl/sha256_round_ctrl.sv | 147 ++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared definitions for the SHA-256 round sequencer.
//   - sha256_state_e : sequencer FSM states
//   - SHA256_ROUNDS  : default number of compression rounds
//   - SCHED_BOUND    : first round whose W comes from the schedule recurrence
//   - SHA256_IV      : initial hash values; these are the DEFAULT_VALUE of the
//                      hash register instances that hash_init reloads
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    UPDATE,
    DONE
  } sha256_state_e;

  localparam int SHA256_ROUNDS = 64;
  localparam int SCHED_BOUND   = 16;

  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// sha256_round_ctrl_if: block-level handshake and datapath control bundle.
//   Host side : start, first_block (in to controller), ready, busy, done.
//   Datapath  : hash_init, load_work, round_en, round_idx, w_sel, hash_we.
//   Optional  : abort / aborted when SHA256_CTRL_ABORT_EN is defined.
// Modports: master = host/datapath side, slave = the sequencer.
interface sha256_round_ctrl_if #(
  parameter int IDX_W = 6
);

  logic             start;
  logic             first_block;
  logic             ready;
  logic             busy;
  logic             hash_init;
  logic             load_work;
  logic             round_en;
  logic [IDX_W-1:0] round_idx;
  logic             w_sel;
  logic             hash_we;
  logic             done;

`ifdef SHA256_CTRL_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output start, first_block, abort,
    input  ready, busy, hash_init, load_work, round_en, round_idx,
           w_sel, hash_we, done, aborted
  );

  modport slave (
    input  start, first_block, abort,
    output ready, busy, hash_init, load_work, round_en, round_idx,
           w_sel, hash_we, done, aborted
  );
`else
  modport master (
    output start, first_block,
    input  ready, busy, hash_init, load_work, round_en, round_idx,
           w_sel, hash_we, done
  );

  modport slave (
    input  start, first_block,
    output ready, busy, hash_init, load_work, round_en, round_idx,
           w_sel, hash_we, done
  );
`endif

endinterface

// File: rtl/sha256_round_counter.sv
// sha256_round_counter: round index counter for the SHA-256 sequencer.
//   clk, reset : clock and synchronous active-high reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance; wraps to 0 after ROUNDS-1
//   count      : current round index
//   tc         : terminal count, high when count == ROUNDS-1
module sha256_round_counter
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] count,
  output logic             tc
);

  assign tc = (count == IDX_W'(ROUNDS - 1));

  // Wrapping on tc leaves the counter at 0 once the last round is done,
  // so round_idx idles at 0 without a separate clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequencer for the SHA-256 compression datapath.
//   clk, reset : clock and synchronous active-high reset
//   bus        : sha256_round_ctrl_if.slave
//                start/first_block in; ready/busy/done to the host;
//                hash_init, load_work, round_en, round_idx, w_sel, hash_we
//                to the hash register bank and round datapath.
// Sequence per accepted block: LOAD -> ROUND x ROUNDS -> UPDATE -> DONE.
// Optional feature macro: SHA256_CTRL_ABORT_EN adds abort/aborted.
// ROUNDS must be >= 16 and 2**IDX_W must be >= ROUNDS.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int IDX_W  = 6
) (
  input logic                clk,
  input logic                reset,
  sha256_round_ctrl_if.slave bus
);

  sha256_state_e    state;
  logic [IDX_W-1:0] count;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_en;
  logic             abort_hit;

  logic ready_q;
  logic busy_q;
  logic hash_init_q;
  logic load_work_q;
  logic round_en_q;
  logic hash_we_q;
  logic done_q;

`ifdef SHA256_CTRL_ABORT_EN
  logic aborted_q;

  // Abort only matters while a block is in flight; IDLE and DONE ignore it.
  assign abort_hit = bus.abort &&
                     (state == LOAD || state == ROUND || state == UPDATE);

  always_ff @(posedge clk) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end

  assign bus.aborted = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // An abort clears the counter too, so the IDLE it lands in shows index 0.
  assign cnt_clr = (state == LOAD) || abort_hit;
  assign cnt_en  = (state == ROUND) && !abort_hit;

  sha256_round_counter #(
    .ROUNDS (ROUNDS),
    .IDX_W  (IDX_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .tc    (tc)
  );

  // Outputs are registered alongside the state transition that enters the
  // state they belong to. hash_init is captured from first_block on the
  // accepting edge, which is the only time first_block is looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      hash_init_q <= 1'b0;
      load_work_q <= 1'b0;
      round_en_q  <= 1'b0;
      hash_we_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      hash_init_q <= 1'b0;
      load_work_q <= 1'b0;
      hash_we_q   <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= LOAD;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            load_work_q <= 1'b1;
            hash_init_q <= bus.first_block;
          end
        end
        LOAD: begin
          state      <= ROUND;
          round_en_q <= 1'b1;
        end
        ROUND: begin
          if (tc) begin
            state      <= UPDATE;
            round_en_q <= 1'b0;
            hash_we_q  <= 1'b1;
          end
        end
        UPDATE: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
      if (abort_hit) begin
        state      <= IDLE;
        ready_q    <= 1'b1;
        busy_q     <= 1'b0;
        round_en_q <= 1'b0;
        hash_we_q  <= 1'b0;
        done_q     <= 1'b0;
      end
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.hash_init = hash_init_q;
  assign bus.load_work = load_work_q;
  assign bus.round_en  = round_en_q;
  assign bus.round_idx = count;
  assign bus.w_sel     = round_en_q && (count >= IDX_W'(SCHED_BOUND));
  assign bus.hash_we   = hash_we_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: self-checking bench for sha256_round_ctrl.
// Expected outputs come from the cycle-offset timeline of a block (cycle 1
// LOAD, cycles 2..ROUNDS+1 rounds, ROUNDS+2 hash add, ROUNDS+3 done,
// ROUNDS+4 idle). Optional macro SHA256_CTRL_ABORT_EN enables the abort test.
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;
  localparam int IDX_W  = 6;
  localparam int VW     = IDX_W + 8;
  localparam int BLK    = ROUNDS + 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sha256_round_ctrl_if #(.IDX_W(IDX_W)) bus ();

  sha256_round_ctrl #(
    .ROUNDS (ROUNDS),
    .IDX_W  (IDX_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Packs the observed outputs as
  // {ready, busy, hash_init, load_work, round_en, round_idx, w_sel, hash_we, done}.
  function automatic logic [VW-1:0] observed();
    return {bus.ready, bus.busy, bus.hash_init, bus.load_work, bus.round_en,
            bus.round_idx, bus.w_sel, bus.hash_we, bus.done};
  endfunction

  // Reference timeline: t = cycles since the accepting edge (t <= 0 or
  // t >= ROUNDS+4 means idle), fb = first_block captured at acceptance.
  function automatic logic [VW-1:0] expected(int t, bit fb);
    logic rdy, bsy, hi, lw, re, ws, hw, dn;
    logic [IDX_W-1:0] idx;
    rdy = 1'b1; bsy = 1'b0; hi = 1'b0; lw = 1'b0;
    re  = 1'b0; ws  = 1'b0; hw = 1'b0; dn = 1'b0;
    idx = '0;
    if (t >= 1 && t <= ROUNDS + 3) begin
      rdy = 1'b0;
      bsy = 1'b1;
    end
    if (t == 1) begin
      hi = fb;
      lw = 1'b1;
    end
    if (t >= 2 && t <= ROUNDS + 1) begin
      re  = 1'b1;
      idx = IDX_W'(t - 2);
      ws  = ((t - 2) >= 16);
    end
    if (t == ROUNDS + 2) hw = 1'b1;
    if (t == ROUNDS + 3) dn = 1'b1;
    return {rdy, bsy, hi, lw, re, idx, ws, hw, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.first_block = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
    bus.abort       = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (observed() !== expected(0, 1'b0)) begin
        bad++;
        $display("[TB] FAIL reset_idle cyc=%0d got=%h want=%h",
                 i, observed(), expected(0, 1'b0));
      end
    end
  endtask

  // First block: hash reinit expected in the LOAD cycle.
  task automatic test_first_block();
    int gap;
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++) begin
      tick();
      total++;
      if (observed() !== expected(0, 1'b0)) begin
        bad++;
        $display("[TB] FAIL first_gap g=%0d got=%h want=%h",
                 g, observed(), expected(0, 1'b0));
      end
    end
    bus.start       = 1'b1;
    bus.first_block = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 1; t <= BLK; t++) begin
      total++;
      if (observed() !== expected(t, 1'b1)) begin
        bad++;
        $display("[TB] FAIL first_block t=%0d got=%h want=%h",
                 t, observed(), expected(t, 1'b1));
      end
      if (t < BLK) begin
        bus.first_block = 1'($urandom);
        tick();
      end
    end
  endtask

  // Continuation block (no reinit), then random blocks with start and
  // first_block toggling randomly while busy to show they are ignored.
  task automatic test_second_block();
    bit fb;
    for (int b = 0; b < 4; b++) begin
      fb = (b == 0) ? 1'b0 : 1'($urandom);
      bus.start       = 1'b1;
      bus.first_block = fb;
      tick();
      bus.start = 1'b0;
      for (int t = 1; t <= BLK; t++) begin
        total++;
        if (observed() !== expected(t, fb)) begin
          bad++;
          $display("[TB] FAIL block b=%0d t=%0d got=%h want=%h",
                   b, t, observed(), expected(t, fb));
        end
        if (t < BLK) begin
          if (b > 0) bus.start = 1'($urandom);
          bus.first_block = 1'($urandom);
          tick();
        end
      end
      bus.start = 1'b0;
    end
  endtask

  // start held high: a new block is taken exactly when ready returns.
  task automatic test_back_to_back();
    bit fb [3];
    for (int b = 0; b < 3; b++) fb[b] = 1'($urandom);
    bus.start       = 1'b1;
    bus.first_block = fb[0];
    tick();
    for (int b = 0; b < 3; b++) begin
      for (int t = 1; t <= BLK; t++) begin
        total++;
        if (observed() !== expected(t, fb[b])) begin
          bad++;
          $display("[TB] FAIL b2b b=%0d t=%0d got=%h want=%h",
                   b, t, observed(), expected(t, fb[b]));
        end
        if (t < BLK) begin
          bus.first_block = 1'($urandom);
          tick();
        end
      end
      if (b < 2) begin
        bus.first_block = fb[b + 1];
        tick();
      end
    end
    bus.start = 1'b0;
    tick();
    total++;
    if (observed() !== expected(0, 1'b0)) begin
      bad++;
      $display("[TB] FAIL b2b_release got=%h want=%h", observed(), expected(0, 1'b0));
    end
  endtask

  // Reset at cycle 30 (round 28), then quiet idle, then a normal block.
  task automatic test_reset_mid();
    bit fb;
    fb = 1'($urandom);
    bus.start       = 1'b1;
    bus.first_block = fb;
    tick();
    bus.start = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      total++;
      if (observed() !== expected(t, fb)) begin
        bad++;
        $display("[TB] FAIL pre_reset t=%0d got=%h want=%h",
                 t, observed(), expected(t, fb));
      end
      if (t < 30) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      total++;
      if (observed() !== expected(0, 1'b0)) begin
        bad++;
        $display("[TB] FAIL post_reset i=%0d got=%h want=%h",
                 i, observed(), expected(0, 1'b0));
      end
      tick();
    end
    fb = 1'($urandom);
    bus.start       = 1'b1;
    bus.first_block = fb;
    tick();
    bus.start = 1'b0;
    for (int t = 1; t <= BLK; t++) begin
      total++;
      if (observed() !== expected(t, fb)) begin
        bad++;
        $display("[TB] FAIL after_reset t=%0d got=%h want=%h",
                 t, observed(), expected(t, fb));
      end
      if (t < BLK) tick();
    end
  endtask

`ifdef SHA256_CTRL_ABORT_EN
  // Abort at cycle 40; abort while idle; abort together with reset.
  task automatic test_abort();
    bit fb;
    fb = 1'($urandom);
    bus.start       = 1'b1;
    bus.first_block = fb;
    tick();
    bus.start = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      total++;
      if (observed() !== expected(t, fb) || bus.aborted !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pre_abort t=%0d got=%h/%b want=%h/0",
                 t, observed(), bus.aborted, expected(t, fb));
      end
      if (t < 40) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    total++;
    if (observed() !== expected(0, 1'b0) || bus.aborted !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_hit got=%h/%b want=%h/1",
               observed(), bus.aborted, expected(0, 1'b0));
    end
    for (int i = 0; i < BLK; i++) begin
      tick();
      bus.abort = (i < 3) ? 1'b1 : 1'b0;
      total++;
      if (observed() !== expected(0, 1'b0) || bus.aborted !== 1'b0) begin
        bad++;
        $display("[TB] FAIL post_abort i=%0d got=%h/%b want=%h/0",
                 i, observed(), bus.aborted, expected(0, 1'b0));
      end
    end
    bus.abort = 1'b0;
    bus.start = 1'b1;
    bus.first_block = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    reset     = 1'b1;
    bus.abort = 1'b1;
    tick();
    reset     = 1'b0;
    bus.abort = 1'b0;
    total++;
    if (observed() !== expected(0, 1'b0) || bus.aborted !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_with_reset got=%h/%b want=%h/0",
               observed(), bus.aborted, expected(0, 1'b0));
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_first_block();
    test_second_block();
    test_back_to_back();
    test_reset_mid();
`ifdef SHA256_CTRL_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
